// File: rtl/coarse_peak_finder.sv
// ---------------------------------------------------------------------------
// coarse_peak_finder
//
// Builds a coarse histogram of TDC timestamps over one frame, using the top
// NB bits of each timestamp as the bin index. When the frame closes, the
// histogram is scanned one bin per cycle for the peak bin. The result is then
// published on peakCH/peakCount together with a one-cycle peakDone pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   tof        in   NP-bit timestamp, bin index = tof[NP-1:NP-NB]
//   tofValid   in   tof is valid this cycle
//   frameEnd   in   one-cycle pulse that closes the current frame
//   busy       out  high while scanning / publishing; events are dropped
//   peakCH     out  index of the peak bin, held until the next peakDone
//   peakCount  out  count of the peak bin, held until the next peakDone
//   peakDone   out  one-cycle pulse when peakCH/peakCount update
//   dropCount  out  (DROP_CNT_EN only) tofValid pulses seen while busy
//
// Optional feature macro: DROP_CNT_EN
//   When this macro is defined, the block adds the 16-bit dropCount output.
//   The output is a saturating count of the events dropped during the
//   previous busy window.
// ---------------------------------------------------------------------------
module coarse_peak_finder #(
   parameter int NB           = 4,
   parameter int NP           = 10,
   parameter int CW           = 8,
   parameter int FRAME_EVENTS = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NP-1:0] tof,
   input  logic          tofValid,
   input  logic          frameEnd,
   output logic          busy,
   output logic [NB-1:0] peakCH,
   output logic [CW-1:0] peakCount,
   output logic          peakDone
`ifdef DROP_CNT_EN
   ,
   output logic [15:0]   dropCount
`endif
);

   localparam int NBINS = 1 << NB;
   // The event counter must be able to hold FRAME_EVENTS. It is never
   // narrower than 16 bits.
   localparam int FEW   = (FRAME_EVENTS > 0) ? $clog2(FRAME_EVENTS + 1) : 1;
   localparam int ECW   = (FEW > 16) ? FEW : 16;
   localparam logic [CW-1:0]  BIN_MAX   = '1;
   localparam logic [ECW-1:0] EVT_LIMIT = ECW'(FRAME_EVENTS);
   localparam logic [NB-1:0]  LAST_IDX  = NB'(NBINS - 1);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCAN  = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_bins [NBINS];
   logic [ECW-1:0] r_evtCnt;
   logic [NB-1:0]  r_scanIdx;
   logic [NB-1:0]  r_bestIdx;
   logic [CW-1:0]  r_best;
   logic           r_busy;
   logic [NB-1:0]  r_peakCH;
   logic [CW-1:0]  r_peakCount;
   logic           r_peakDone;

   logic [NB-1:0]  w_binIdx;
   logic [ECW-1:0] w_evtNext;
   logic           w_autoClose;
   logic           w_close;
   logic [CW-1:0]  w_scanVal;
   logic           w_take;
   logic [CW-1:0]  w_nextBest;
   logic [NB-1:0]  w_nextIdx;
   logic           w_unusedTof;

   // The lower timestamp bits only refine position inside a coarse bin. The
   // histogram does not need them.
   assign w_unusedTof = ^tof;
   assign w_binIdx    = tof[NP-1:NP-NB];
   assign w_evtNext   = r_evtCnt + 1'b1;

   // Auto-close fires on the event that brings the counter up to
   // FRAME_EVENTS. A value of zero disables auto-close entirely.
   assign w_autoClose = (FRAME_EVENTS != 0) && tofValid && (w_evtNext == EVT_LIMIT);
   assign w_close     = frameEnd || w_autoClose;

   // The scan compare is strict. Because of that, the earliest (lowest-index)
   // bin wins a tie.
   assign w_scanVal  = r_bins[r_scanIdx];
   assign w_take     = w_scanVal > r_best;
   assign w_nextBest = w_take ? w_scanVal : r_best;
   assign w_nextIdx  = w_take ? r_scanIdx : r_bestIdx;

   assign busy      = r_busy;
   assign peakCH    = r_peakCH;
   assign peakCount = r_peakCount;
   assign peakDone  = r_peakDone;

   // Main control.
   // ACCUM fills the histogram. SCAN walks the bins once, from index 0 up to
   // the last bin. On the last scan step, the final winner is loaded straight
   // into the output registers, so peakDone is high during the DONE cycle.
   // DONE then wipes the histogram for the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ACCUM;
         for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
         r_evtCnt    <= '0;
         r_scanIdx   <= '0;
         r_bestIdx   <= '0;
         r_best      <= '0;
         r_busy      <= 1'b0;
         r_peakCH    <= '0;
         r_peakCount <= '0;
         r_peakDone  <= 1'b0;
      end else begin
         r_peakDone <= 1'b0;
         case (r_state)
            ACCUM: begin
               if (tofValid) begin
                  if (r_bins[w_binIdx] != BIN_MAX) begin
                     r_bins[w_binIdx] <= r_bins[w_binIdx] + 1'b1;
                  end
                  r_evtCnt <= w_evtNext;
               end
               if (w_close) begin
                  r_state   <= SCAN;
                  r_busy    <= 1'b1;
                  r_scanIdx <= '0;
                  r_bestIdx <= '0;
                  r_best    <= '0;
               end
            end
            SCAN: begin
               r_best    <= w_nextBest;
               r_bestIdx <= w_nextIdx;
               r_scanIdx <= r_scanIdx + 1'b1;
               if (r_scanIdx == LAST_IDX) begin
                  r_state     <= DONE;
                  r_peakCH    <= w_nextIdx;
                  r_peakCount <= w_nextBest;
                  r_peakDone  <= 1'b1;
               end
            end
            DONE: begin
               for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
               r_evtCnt <= '0;
               r_busy   <= 1'b0;
               r_state  <= ACCUM;
            end
            default: begin
               r_state <= ACCUM;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DROP_CNT_EN
   logic [15:0] r_dropCnt;
   logic [15:0] r_dropCount;
   logic [15:0] w_dropNext;

   assign w_dropNext = (r_dropCnt != 16'hFFFF) ? r_dropCnt + 16'd1 : r_dropCnt;
   assign dropCount  = r_dropCount;

   // Drop accounting.
   // Every tofValid seen while busy is counted, and the count saturates.
   // The total is published together with the peak result, and a drop that
   // arrives on that same last scan cycle is included in it. The internal
   // counter then restarts, so a drop during DONE is charged to the next
   // frame's window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dropCnt   <= '0;
         r_dropCount <= '0;
      end else if (r_state == SCAN && r_scanIdx == LAST_IDX) begin
         r_dropCount <= tofValid ? w_dropNext : r_dropCnt;
         r_dropCnt   <= '0;
      end else if (r_busy && tofValid) begin
         r_dropCnt <= w_dropNext;
      end
   end
`endif

endmodule

// File: tb/tb_coarse_peak_finder.sv
// ---------------------------------------------------------------------------
// tb_coarse_peak_finder
//
// Two instances are used: one with frameEnd-only closing and one with
// FRAME_EVENTS=8 auto-close. A per-frame histogram model is kept as plain
// integer arrays. The expected peak is the lowest index of the largest
// saturated count.
// ---------------------------------------------------------------------------
module tb_coarse_peak_finder;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] tofS        [2];
   logic       tofValidS   [2];
   logic       frameEndS   [2];
   logic       busyS       [2];
   logic [3:0] peakCHS     [2];
   logic [7:0] peakCountS  [2];
   logic       peakDoneS   [2];
`ifdef DROP_CNT_EN
   logic [15:0] dropCountS [2];
`endif

   int errors = 0;
   int checks = 0;
   int modelBins  [2][16];
   int modelDrops [2];

   always #5 clk = ~clk;

   coarse_peak_finder #(.NB(4), .NP(10), .CW(8), .FRAME_EVENTS(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .tof       (tofS[0]),
      .tofValid  (tofValidS[0]),
      .frameEnd  (frameEndS[0]),
      .busy      (busyS[0]),
      .peakCH    (peakCHS[0]),
      .peakCount (peakCountS[0]),
      .peakDone  (peakDoneS[0])
`ifdef DROP_CNT_EN
      ,
      .dropCount (dropCountS[0])
`endif
   );

   coarse_peak_finder #(.NB(4), .NP(10), .CW(8), .FRAME_EVENTS(8)) dutAuto (
      .clk       (clk),
      .rst       (rst),
      .tof       (tofS[1]),
      .tofValid  (tofValidS[1]),
      .frameEnd  (frameEndS[1]),
      .busy      (busyS[1]),
      .peakCH    (peakCHS[1]),
      .peakCount (peakCountS[1]),
      .peakDone  (peakDoneS[1])
`ifdef DROP_CNT_EN
      ,
      .dropCount (dropCountS[1])
`endif
   );

   // Compare one observed value against its expectation and count it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle on instance d. The other instance sits idle. Accepted
   // events are added to the model.
   task automatic applyStimulus(input int d, input bit valid, input bit close,
                                input logic [9:0] t);
      @(negedge clk);
      for (int e = 0; e < 2; e++) begin
         tofValidS[e] = 1'b0;
         frameEndS[e] = 1'b0;
      end
      tofS[d]      = t;
      tofValidS[d] = valid;
      frameEndS[d] = close;
      if (valid) modelBins[d][t[9:6]]++;
   endtask

   task automatic clearModel(input int d);
      for (int i = 0; i < 16; i++) modelBins[d][i] = 0;
   endtask

   // Called right after the closing cycle. This task checks latency, the busy
   // window and the published result. It also injects ignored traffic while
   // busy (dropMode < 0 means random, otherwise exactly dropMode drops).
   task automatic waitPeak(input int d, input string tag, input int dropMode);
      int expCH, expCnt, c, doneAt, busyCnt;
      bit v;
      expCH = 0; expCnt = 0;
      for (int i = 0; i < 16; i++) begin
         c = (modelBins[d][i] > 255) ? 255 : modelBins[d][i];
         if (c > expCnt) begin
            expCnt = c;
            expCH  = i;
         end
      end
      doneAt = 0; busyCnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busyS[d]) busyCnt++;
         if (peakDoneS[d]) begin
            doneAt = k;
            break;
         end
         v = 1'b0;
         if (k < 15) v = (dropMode < 0) ? 1'($urandom_range(0, 1)) : (k <= dropMode);
         tofValidS[d] = v;
         tofS[d]      = 10'($urandom);
         frameEndS[d] = (k < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (v) modelDrops[d]++;
      end
      checkOutput({tag, ".latency"}, doneAt, 17);
      checkOutput({tag, ".busyCycles"}, busyCnt, 17);
      checkOutput({tag, ".peakCH"}, peakCHS[d], expCH);
      checkOutput({tag, ".peakCount"}, peakCountS[d], expCnt);
`ifdef DROP_CNT_EN
      checkOutput({tag, ".dropCount"}, dropCountS[d], modelDrops[d]);
`endif
      modelDrops[d] = 0;
      clearModel(d);
   endtask

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [9:0] t;
      int n;
      bit narrow;
      for (int e = 0; e < 2; e++) begin
         tofS[e] = '0; tofValidS[e] = 1'b0; frameEndS[e] = 1'b0;
         modelDrops[e] = 0;
         clearModel(e);
      end

      // Reset state.
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset.peakDone", peakDoneS[0], 0);
      end
      checkOutput("reset.busy", busyS[0], 0);
      checkOutput("reset.peakCH", peakCHS[0], 0);
      checkOutput("reset.peakCount", peakCountS[0], 0);
      checkOutput("reset.autoBusy", busyS[1], 0);
      rst = 1'b0;

      // Basic peak: 5 events in bin 3 and 2 in bin 9.
      repeat (5) applyStimulus(0, 1, 0, 10'h0C0);
      repeat (2) applyStimulus(0, 1, 0, 10'h240);
      applyStimulus(0, 0, 1, 10'h000);
      waitPeak(0, "basic", -1);
      checkOutput("basic.ch3", peakCHS[0], 3);
      checkOutput("basic.count5", peakCountS[0], 5);

      // Outputs hold and peakDone stays low afterwards.
      repeat (3) applyStimulus(0, 0, 0, 10'h000);
      checkOutput("hold.peakDone", peakDoneS[0], 0);
      checkOutput("hold.peakCH", peakCHS[0], 3);

      // Tie resolves to the lowest index.
      repeat (4) applyStimulus(0, 1, 0, 10'h1C0);
      repeat (4) applyStimulus(0, 1, 0, 10'h080);
      applyStimulus(0, 0, 1, 10'h000);
      waitPeak(0, "tie", -1);
      checkOutput("tie.ch2", peakCHS[0], 2);

      // Saturation, then a back-to-back empty frame proving bins were cleared.
      repeat (300) applyStimulus(0, 1, 0, 10'h3C0);
      applyStimulus(0, 0, 1, 10'h000);
      waitPeak(0, "sat", -1);
      checkOutput("sat.count255", peakCountS[0], 255);
      applyStimulus(0, 0, 1, 10'h000);
      waitPeak(0, "empty", 3);

      // Two saturated bins tie at the ceiling; the lower one wins. The
      // closing cycle also carries an event that must still count.
      repeat (300) applyStimulus(0, 1, 0, 10'h240);
      repeat (299) applyStimulus(0, 1, 0, 10'h140);
      applyStimulus(0, 1, 1, 10'h140);
      waitPeak(0, "satTie", -1);
      checkOutput("satTie.ch5", peakCHS[0], 5);

      // Reset in the middle of a scan aborts it without a result.
      repeat (3) applyStimulus(0, 1, 0, 10'h040);
      applyStimulus(0, 0, 1, 10'h000);
      repeat (5) applyStimulus(0, 0, 0, 10'h000);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("midReset.peakDone", peakDoneS[0], 0);
      end
      checkOutput("midReset.busy", busyS[0], 0);
      checkOutput("midReset.peakCH", peakCHS[0], 0);
      checkOutput("midReset.peakCount", peakCountS[0], 0);
      rst = 1'b0;
      for (int e = 0; e < 2; e++) begin
         clearModel(e);
         modelDrops[e] = 0;
      end
      repeat (2) applyStimulus(0, 1, 0, 10'h300);
      applyStimulus(0, 0, 1, 10'h000);
      waitPeak(0, "postReset", -1);

      // Auto-close after 8 events on the second instance.
      repeat (8) applyStimulus(1, 1, 0, 10'h100);
      waitPeak(1, "auto", -1);
      checkOutput("auto.ch4", peakCHS[1], 4);
      checkOutput("auto.count8", peakCountS[1], 8);
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) applyStimulus(1, 0, 0, 10'h000);
            applyStimulus(1, 1, 0, 10'($urandom));
         end
         waitPeak(1, "autoRand", -1);
      end

      // Randomized frames, some narrowed to four bins to force ties.
      for (int f = 0; f < 10; f++) begin
         n = $urandom_range(0, 60);
         narrow = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(0, 0, 0, 10'h000);
            t = 10'($urandom);
            if (narrow) t[9:6] = 4'($urandom_range(0, 3));
            applyStimulus(0, 1, 0, t);
         end
         t = 10'($urandom);
         applyStimulus(0, 1'($urandom_range(0, 1)), 1, t);
         waitPeak(0, "rand", -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
